ama_riscv_scoreboard: RTL and testbench

AMA_RISCV_SCOREBOARD -- requirements
Module: ama_riscv_scoreboard

---
 rtl/ama_riscv_scoreboard_pkg.sv | 20 ++
 rtl/ama_riscv_scoreboard_entry.sv | 57 +++++
 rtl/ama_riscv_scoreboard.sv | 69 ++++++
 tb/tb_ama_riscv_scoreboard.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ama_riscv_scoreboard_pkg.sv
// rtl/ama_riscv_scoreboard_pkg.sv - shared latency encodings and register-file constants
package ama_riscv_scoreboard_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam logic [4:0]  RF_X0_ZERO = 5'd0;

    localparam logic [1:0]  LAT_LONG   = 2'd0;
    localparam logic [1:0]  LAT_ALU    = 2'd1;
    localparam logic [1:0]  LAT_LOAD   = 2'd2;

    function automatic logic [4:0] popcount_regs(input logic [NUM_REGS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ama_riscv_scoreboard_entry.sv
// rtl/ama_riscv_scoreboard_entry.sv - one register's in-flight producer state and countdown
module ama_riscv_sb_entry
    import ama_riscv_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_i,
    input  logic [1:0] lat_i,
    input  logic       wb_clr_i,
    input  logic       flush_i,
    output logic       pending_o,
    output logic       ready_o,
    output logic       pending_nxt_o
);

    logic       pending_q, pending_d;
    logic       long_q, long_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        pending_d = pending_q;
        long_d    = long_q;
        cnt_d     = cnt_q;
        if (pending_q && !long_q && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
        if (wb_clr_i || (flush_i && !long_q)) begin
            pending_d = 1'b0;
            long_d    = 1'b0;
            cnt_d     = 2'd0;
        end
        // A new producer overrides a same-cycle writeback of the old one.
        if (issue_i) begin
            pending_d = 1'b1;
            long_d    = (lat_i == LAT_LONG);
            cnt_d     = lat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            long_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            pending_q <= pending_d;
            long_q    <= long_d;
            cnt_q     <= cnt_d;
        end
    end

    // cnt of 1 means the result reaches the bypass network during this cycle.
    assign ready_o       = pending_q && !long_q && (cnt_q <= 2'd1);
    assign pending_o     = pending_q;
    assign pending_nxt_o = pending_d;

endmodule

// File: rtl/ama_riscv_scoreboard.sv
// rtl/ama_riscv_scoreboard.sv - register scoreboard producing RAW/WAW hazard stalls
module ama_riscv_scoreboard
    import ama_riscv_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       rd_we_id,
    input  logic [4:0] rd_id,
    input  logic [1:0] issue_lat,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       flush,
    output logic       stall,
    output logic [4:0] pending_cnt
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] rdy;
    logic [NUM_REGS-1:0] pend_nxt;
    logic                issue_accept;
    logic                raw_rs1, raw_rs2, waw;
    logic [4:0]          pending_cnt_q;

    assign pend[0]     = 1'b0;
    assign rdy[0]      = 1'b0;
    assign pend_nxt[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        ama_riscv_sb_entry u_entry (
            .clk           (clk),
            .rst           (rst),
            .issue_i       (issue_accept && (rd_id == 5'(i))),
            .lat_i         (issue_lat),
            .wb_clr_i      (wb_valid && (wb_rd == 5'(i))),
            .flush_i       (flush),
            .pending_o     (pend[i]),
            .ready_o       (rdy[i]),
            .pending_nxt_o (pend_nxt[i])
        );
    end

    always_comb begin
        raw_rs1 = rs1_used && (rs1_id != RF_X0_ZERO) && pend[rs1_id] && !rdy[rs1_id]
                  && !(wb_valid && (wb_rd == rs1_id));
        raw_rs2 = rs2_used && (rs2_id != RF_X0_ZERO) && pend[rs2_id] && !rdy[rs2_id]
                  && !(wb_valid && (wb_rd == rs2_id));
        waw     = issue_valid && rd_we_id && (rd_id != RF_X0_ZERO) && pend[rd_id]
                  && !(wb_valid && (wb_rd == rd_id));
        stall   = (raw_rs1 || raw_rs2 || waw) && issue_valid && !flush;
        issue_accept = issue_valid && rd_we_id && (rd_id != RF_X0_ZERO) && !stall && !flush;
    end

    // Counting the next-state table keeps the count exact across issue, writeback and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_cnt_q <= 5'd0;
        end else begin
            pending_cnt_q <= popcount_regs(pend_nxt);
        end
    end

    assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_ama_riscv_scoreboard.sv
// tb/tb_ama_riscv_scoreboard.sv - directed self-checking bench for ama_riscv_scoreboard
module tb_ama_riscv_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic       rd_we_id = 1'b0;
    logic [4:0] rd_id = '0;
    logic [1:0] issue_lat = '0;
    logic [4:0] rs1_id = '0;
    logic [4:0] rs2_id = '0;
    logic       rs1_used = 1'b0;
    logic       rs2_used = 1'b0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_rd = '0;
    logic       flush = 1'b0;
    logic       stall;
    logic [4:0] pending_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ama_riscv_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .rd_we_id    (rd_we_id),
        .rd_id       (rd_id),
        .issue_lat   (issue_lat),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .stall       (stall),
        .pending_cnt (pending_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next cycle and apply a fresh set of inputs.
    task automatic cyc(input logic iv, input logic we, input logic [4:0] rd, input logic [1:0] lat,
                       input logic r1u, input logic [4:0] r1, input logic r2u, input logic [4:0] r2,
                       input logic wbv, input logic [4:0] wbr, input logic fl);
        @(negedge clk);
        issue_valid = iv; rd_we_id = we; rd_id = rd; issue_lat = lat;
        rs1_used = r1u; rs1_id = r1; rs2_used = r2u; rs2_id = r2;
        wb_valid = wbv; wb_rd = wbr; flush = fl;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset with a read of x5 presented: table empty, so no stall
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_cnt", pending_cnt, 0);
        rst = 1'b0;

        // ALU producer x5 then immediate consumer
        cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("alu_issue_stall", stall, 0);
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        check_eq("alu_use_stall", stall, 0);
        check_eq("alu_cnt", pending_cnt, 1);
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        check_eq("alu_use2_stall", stall, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        idle();
        check_eq("alu_wb_cnt", pending_cnt, 0);

        // Load producer x6: one bubble for an rs2 consumer
        cyc(1, 1, 6, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        check_eq("load_use_stall", stall, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        check_eq("load_use_release", stall, 0);
        check_eq("load_cnt", pending_cnt, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);

        // Long-latency x7 held until its writeback bypasses
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        check_eq("long_stall_a", stall, 1);
        cyc(1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        check_eq("long_stall_b", stall, 1);
        cyc(1, 0, 0, 0, 1, 7, 0, 0, 1, 7, 0);
        check_eq("long_wb_bypass", stall, 0);
        idle();
        check_eq("long_wb_cnt", pending_cnt, 0);

        // x0 is never tracked
        cyc(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        check_eq("x0_stall", stall, 0);
        idle();
        check_eq("x0_cnt", pending_cnt, 0);

        // Same-cycle issue and writeback of x9: the new producer stays pending
        cyc(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 9, 0, 0, 0, 0, 0, 1, 9, 0);
        check_eq("x9_reissue_stall", stall, 0);
        check_eq("x9_cnt_before", pending_cnt, 1);
        cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        check_eq("x9_cnt_after", pending_cnt, 1);
        check_eq("x9_still_pending", stall, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

        // WAW on a ready but unretired x10
        cyc(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("waw_stall", stall, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0);
        idle();
        check_eq("waw_clr_cnt", pending_cnt, 0);

        // Flush clears the load x3 but keeps the long x4
        cyc(1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 4, 1, 3, 0, 0, 1);
        check_eq("flush_cnt_before", pending_cnt, 2);
        check_eq("flush_no_stall", stall, 0);
        cyc(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        check_eq("flush_cnt_after", pending_cnt, 1);
        check_eq("flush_x3_cleared", stall, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        check_eq("flush_x4_kept", stall, 1);

        // Mid-operation reset drops x4; its late writeback must not underflow
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_cnt", pending_cnt, 0);
        check_eq("midrst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        cyc(1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        check_eq("postrst_wb_cnt", pending_cnt, 0);
        check_eq("postrst_stall", stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
